// File: rtl/testdrive_slave_regfile.sv
// testdrive_slave_regfile
//   Slave-side register file for the TestDrive simple register bus.
//   Holds ID/CTRL/STATUS/SCRATCH/IRQ registers and a command FIFO that user
//   logic drains through a valid/ready port.
// Ports:
//   CLK, nRST           clock, synchronous active-low reset
//   WE/WADDR/WDATA      write channel (1-cycle latency, no backpressure)
//   RE/RADDR/RDATA      read channel (RDATA registered, holds until next RE)
//   CTRL                CTRL register contents
//   STATUS_IN           user status returned by the STATUS register
//   CMD_VALID/CMD_DATA  FIFO head presentation (registered)
//   CMD_READY           user accepts the head entry
//   IRQ_SRC             level interrupt sources
//   IRQ                 registered |(PEND & MASK)
module testdrive_slave_regfile #(
  parameter int unsigned C_ADDR_BITS  = 10,
  parameter logic [31:0] C_ID         = 32'h5444_0001,
  parameter logic [31:0] C_CTRL_RESET = 32'h0,
  parameter int unsigned C_FIFO_DEPTH = 16,
  parameter int unsigned C_IRQ_BITS   = 8
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   WE,
  input  logic [C_ADDR_BITS-1:0] WADDR,
  input  logic [31:0]            WDATA,
  input  logic                   RE,
  input  logic [C_ADDR_BITS-1:0] RADDR,
  output logic [31:0]            RDATA,
  output logic [31:0]            CTRL,
  input  logic [31:0]            STATUS_IN,
  output logic                   CMD_VALID,
  output logic [31:0]            CMD_DATA,
  input  logic                   CMD_READY,
  input  logic [C_IRQ_BITS-1:0]  IRQ_SRC,
  output logic                   IRQ
);

  localparam int unsigned PW = $clog2(C_FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;

  localparam logic [C_ADDR_BITS-1:0] A_ID      = C_ADDR_BITS'(0);
  localparam logic [C_ADDR_BITS-1:0] A_CTRL    = C_ADDR_BITS'(1);
  localparam logic [C_ADDR_BITS-1:0] A_STATUS  = C_ADDR_BITS'(2);
  localparam logic [C_ADDR_BITS-1:0] A_PUSH    = C_ADDR_BITS'(3);
  localparam logic [C_ADDR_BITS-1:0] A_FSTAT   = C_ADDR_BITS'(4);
  localparam logic [C_ADDR_BITS-1:0] A_PEND    = C_ADDR_BITS'(5);
  localparam logic [C_ADDR_BITS-1:0] A_MASK    = C_ADDR_BITS'(6);
  localparam logic [C_ADDR_BITS-1:0] A_SCRATCH = C_ADDR_BITS'(7);

  logic [31:0]           r_rdata;
  logic [31:0]           r_ctrl;
  logic [31:0]           r_scratch;
  logic [C_IRQ_BITS-1:0] r_pend;
  logic [C_IRQ_BITS-1:0] r_mask;
  logic                  r_ovf;
  logic                  r_irq;
  logic [31:0]           r_mem [C_FIFO_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [LW-1:0]         r_level;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push_req;
  logic                  w_push;
  logic                  w_ovf_set;
  logic                  w_ovf_clr;
  logic [C_IRQ_BITS-1:0] w_pend_clr;
  logic [31:0]           w_fifo_stat;
  logic [31:0]           w_rd_mux;

  // FIFO status and handshake qualification
  assign w_full      = (r_level == LW'(C_FIFO_DEPTH));
  assign w_empty     = (r_level == '0);
  assign w_pop       = nRST & !w_empty & CMD_READY;
  assign w_push_req  = nRST & WE & (WADDR == A_PUSH);
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push      = w_push_req & (!w_full | w_pop);
  assign w_ovf_set   = w_push_req & !w_push;
  assign w_ovf_clr   = RE & (RADDR == A_FSTAT);
  assign w_pend_clr  = (WE && (WADDR == A_PEND)) ? WDATA[C_IRQ_BITS-1:0] : '0;
  assign w_fifo_stat = {r_ovf, w_full, w_empty, 20'd0, 9'(r_level)};

  // Read decode; unmapped and write-only addresses return 0
  always_comb begin
    w_rd_mux = '0;
    case (RADDR)
      A_ID:      w_rd_mux = C_ID;
      A_CTRL:    w_rd_mux = r_ctrl;
      A_STATUS:  w_rd_mux = STATUS_IN;
      A_FSTAT:   w_rd_mux = w_fifo_stat;
      A_PEND:    w_rd_mux = 32'(r_pend);
      A_MASK:    w_rd_mux = 32'(r_mask);
      A_SCRATCH: w_rd_mux = r_scratch;
      default:   w_rd_mux = '0;
    endcase
  end

  // Register file, FIFO pointers, interrupt logic
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_rdata   <= '0;
      r_ctrl    <= C_CTRL_RESET;
      r_scratch <= '0;
      r_pend    <= '0;
      r_mask    <= '0;
      r_ovf     <= 1'b0;
      r_irq     <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
    end else begin
      if (RE) r_rdata <= w_rd_mux;
      if (WE) begin
        if (WADDR == A_CTRL)    r_ctrl    <= WDATA;
        if (WADDR == A_MASK)    r_mask    <= WDATA[C_IRQ_BITS-1:0];
        if (WADDR == A_SCRATCH) r_scratch <= WDATA;
      end
      // Set has priority over write-1-to-clear
      r_pend <= (r_pend & ~w_pend_clr) | IRQ_SRC;
      r_irq  <= |(r_pend & r_mask);
      // A new overflow in the clearing-read cycle keeps OVF set
      r_ovf  <= w_ovf_set | (r_ovf & !w_ovf_clr);
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (w_pop && !w_push) r_level <= r_level - LW'(1);
    end
  end

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= WDATA;
  end

  assign RDATA     = r_rdata;
  assign CTRL      = r_ctrl;
  assign CMD_VALID = !w_empty;
  assign CMD_DATA  = r_mem[r_rptr];
  assign IRQ       = r_irq;

endmodule

// File: tb/tb_testdrive_slave_regfile.sv
// Directed testbench for testdrive_slave_regfile.
module tb_testdrive_slave_regfile;

  localparam int unsigned AW = 10;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          WE;
  logic [AW-1:0] WADDR;
  logic [31:0]   WDATA;
  logic          RE;
  logic [AW-1:0] RADDR;
  logic [31:0]   RDATA;
  logic [31:0]   CTRL;
  logic [31:0]   STATUS_IN;
  logic          CMD_VALID;
  logic [31:0]   CMD_DATA;
  logic          CMD_READY;
  logic [7:0]    IRQ_SRC;
  logic          IRQ;

  int n_cmp = 0;
  int n_err = 0;

  testdrive_slave_regfile #(
    .C_ADDR_BITS (AW),
    .C_ID        (32'h5444_0001),
    .C_CTRL_RESET(32'hA5),
    .C_FIFO_DEPTH(16),
    .C_IRQ_BITS  (8)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .WE       (WE),
    .WADDR    (WADDR),
    .WDATA    (WDATA),
    .RE       (RE),
    .RADDR    (RADDR),
    .RDATA    (RDATA),
    .CTRL     (CTRL),
    .STATUS_IN(STATUS_IN),
    .CMD_VALID(CMD_VALID),
    .CMD_DATA (CMD_DATA),
    .CMD_READY(CMD_READY),
    .IRQ_SRC  (IRQ_SRC),
    .IRQ      (IRQ)
  );

  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled on the falling edge
  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge CLK);
    WE = 1'b1; WADDR = a; WDATA = d;
    @(negedge CLK);
    WE = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d);
    @(negedge CLK);
    RE = 1'b1; RADDR = a;
    @(negedge CLK);
    RE = 1'b0;
    d = RDATA;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] exp_rd [5];
    logic [AW-1:0] addr [5];
    addr   = '{10'd0, 10'd1, 10'd6, 10'd7, 10'd9};
    exp_rd = '{32'h5444_0001, 32'hA5, 32'h0, 32'h0, 32'h0};
    @(negedge CLK);
    nRST = 1'b0; WE = 1'b1; WADDR = 10'd7; WDATA = 32'hFFFF_FFFF;
    RE = 1'b1; RADDR = 10'd0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1; WE = 1'b0; RE = 1'b0;
    n_cmp++; if (RDATA !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h exp %h", RDATA, 32'h0); end
    n_cmp++; if (CTRL !== 32'hA5) begin n_err++; $display("FAIL rst_ctrl got %h exp %h", CTRL, 32'hA5); end
    n_cmp++; if (CMD_VALID !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", CMD_VALID); end
    n_cmp++; if (IRQ !== 1'b0) begin n_err++; $display("FAIL rst_irq got %b exp 0", IRQ); end
    for (int i = 0; i < 5; i++) begin
      do_read(addr[i], d);
      n_cmp++;
      if (d !== exp_rd[i]) begin
        n_err++; $display("FAIL rst_read addr %0d got %h exp %h", addr[i], d, exp_rd[i]);
      end
    end
  endtask

  task automatic test_rw_collision();
    logic [31:0] d;
    @(negedge CLK);
    WE = 1'b1; WADDR = 10'd7; WDATA = 32'hDEAD_BEEF; RE = 1'b1; RADDR = 10'd7;
    @(negedge CLK);
    WE = 1'b0; RE = 1'b0;
    n_cmp++; if (RDATA !== 32'h0) begin n_err++; $display("FAIL collide_old got %h exp 0", RDATA); end
    @(negedge CLK);
    n_cmp++; if (RDATA !== 32'h0) begin n_err++; $display("FAIL rdata_hold got %h exp 0", RDATA); end
    do_read(10'd7, d);
    n_cmp++; if (d !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL scratch_rd got %h exp deadbeef", d); end
    do_write(10'd1, 32'h1234_5678);
    n_cmp++; if (CTRL !== 32'h1234_5678) begin n_err++; $display("FAIL ctrl_out got %h exp 12345678", CTRL); end
    do_write(10'd0, 32'h0);
    do_read(10'd0, d);
    n_cmp++; if (d !== 32'h5444_0001) begin n_err++; $display("FAIL id_ro got %h exp 54440001", d); end
    STATUS_IN = 32'hCAFE_0001;
    do_write(10'd2, 32'h0);
    do_read(10'd2, d);
    n_cmp++; if (d !== 32'hCAFE_0001) begin n_err++; $display("FAIL status got %h exp cafe0001", d); end
    do_write(10'd8, 32'h5555_5555);
    do_read(10'd8, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL unmapped got %h exp 0", d); end
    do_write(10'd263, 32'h7777_7777);
    do_read(10'd7, d);
    n_cmp++; if (d !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL alias_wr got %h exp deadbeef", d); end
    do_read(10'd3, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL push_rd got %h exp 0", d); end
  endtask

  task automatic test_fifo_fill();
    logic [31:0] d;
    CMD_READY = 1'b0;
    for (int i = 1; i <= 17; i++) do_write(10'd3, 32'(i));
    do_read(10'd4, d);
    n_cmp++; if (d !== 32'hC000_0010) begin n_err++; $display("FAIL fill_stat got %h exp c0000010", d); end
    do_read(10'd4, d);
    n_cmp++; if (d !== 32'h4000_0010) begin n_err++; $display("FAIL ovf_clear got %h exp 40000010", d); end
    @(negedge CLK);
    CMD_READY = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      n_cmp++;
      if (CMD_VALID !== 1'b1 || CMD_DATA !== 32'(i)) begin
        n_err++; $display("FAIL drain_%0d got v=%b d=%h exp v=1 d=%h", i, CMD_VALID, CMD_DATA, 32'(i));
      end
      @(negedge CLK);
    end
    CMD_READY = 1'b0;
    n_cmp++; if (CMD_VALID !== 1'b0) begin n_err++; $display("FAIL drain_empty got %b exp 0", CMD_VALID); end
    do_read(10'd4, d);
    n_cmp++; if (d !== 32'h2000_0000) begin n_err++; $display("FAIL empty_stat got %h exp 20000000", d); end
  endtask

  task automatic test_full_pop();
    logic [31:0] d;
    logic [31:0] e;
    CMD_READY = 1'b0;
    for (int i = 0; i < 16; i++) do_write(10'd3, 32'h100 + 32'(i));
    @(negedge CLK);
    WE = 1'b1; WADDR = 10'd3; WDATA = 32'h99; CMD_READY = 1'b1;
    @(negedge CLK);
    WE = 1'b0; CMD_READY = 1'b0;
    do_read(10'd4, d);
    n_cmp++; if (d !== 32'h4000_0010) begin n_err++; $display("FAIL fullpop_stat got %h exp 40000010", d); end
    @(negedge CLK);
    CMD_READY = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      e = (i == 16) ? 32'h99 : 32'h100 + 32'(i);
      n_cmp++;
      if (CMD_VALID !== 1'b1 || CMD_DATA !== e) begin
        n_err++; $display("FAIL fullpop_%0d got v=%b d=%h exp v=1 d=%h", i, CMD_VALID, CMD_DATA, e);
      end
      @(negedge CLK);
    end
    CMD_READY = 1'b0;
    n_cmp++; if (CMD_VALID !== 1'b0) begin n_err++; $display("FAIL fullpop_empty got %b exp 0", CMD_VALID); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    do_write(10'd6, 32'hFFFF_FFFF);
    do_read(10'd6, d);
    n_cmp++; if (d !== 32'hFF) begin n_err++; $display("FAIL mask_width got %h exp ff", d); end
    do_write(10'd6, 32'h4);
    @(negedge CLK);
    IRQ_SRC = 8'h04;
    @(negedge CLK);
    IRQ_SRC = 8'h00;
    n_cmp++; if (IRQ !== 1'b0) begin n_err++; $display("FAIL irq_lag got %b exp 0", IRQ); end
    do_read(10'd5, d);
    n_cmp++; if (d !== 32'h4) begin n_err++; $display("FAIL pend_set got %h exp 4", d); end
    n_cmp++; if (IRQ !== 1'b1) begin n_err++; $display("FAIL irq_rise got %b exp 1", IRQ); end
    @(negedge CLK);
    WE = 1'b1; WADDR = 10'd5; WDATA = 32'h4; IRQ_SRC = 8'h04;
    @(negedge CLK);
    WE = 1'b0; IRQ_SRC = 8'h00;
    do_read(10'd5, d);
    n_cmp++; if (d !== 32'h4) begin n_err++; $display("FAIL set_wins got %h exp 4", d); end
    do_write(10'd5, 32'h4);
    n_cmp++; if (IRQ !== 1'b1) begin n_err++; $display("FAIL irq_hold got %b exp 1", IRQ); end
    @(negedge CLK);
    n_cmp++; if (IRQ !== 1'b0) begin n_err++; $display("FAIL irq_fall got %b exp 0", IRQ); end
    do_read(10'd5, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL pend_clr got %h exp 0", d); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    CMD_READY = 1'b0;
    for (int i = 0; i < 17; i++) do_write(10'd3, 32'h200 + 32'(i));
    @(negedge CLK);
    CMD_READY = 1'b1;
    repeat (11) @(negedge CLK);
    CMD_READY = 1'b0;
    IRQ_SRC = 8'h04;
    @(negedge CLK);
    IRQ_SRC = 8'h00;
    @(negedge CLK);
    n_cmp++; if (CMD_VALID !== 1'b1 || CMD_DATA !== 32'h20B) begin
      n_err++; $display("FAIL pre_rst_fifo got v=%b d=%h exp v=1 d=0000020b", CMD_VALID, CMD_DATA);
    end
    n_cmp++; if (IRQ !== 1'b1) begin n_err++; $display("FAIL pre_rst_irq got %b exp 1", IRQ); end
    nRST = 1'b0; WE = 1'b1; WADDR = 10'd7; WDATA = 32'h1111_1111;
    @(negedge CLK);
    nRST = 1'b1; WE = 1'b0;
    n_cmp++; if (CMD_VALID !== 1'b0) begin n_err++; $display("FAIL mrst_valid got %b exp 0", CMD_VALID); end
    n_cmp++; if (IRQ !== 1'b0) begin n_err++; $display("FAIL mrst_irq got %b exp 0", IRQ); end
    n_cmp++; if (CTRL !== 32'hA5) begin n_err++; $display("FAIL mrst_ctrl got %h exp a5", CTRL); end
    n_cmp++; if (RDATA !== 32'h0) begin n_err++; $display("FAIL mrst_rdata got %h exp 0", RDATA); end
    do_read(10'd4, d);
    n_cmp++; if (d !== 32'h2000_0000) begin n_err++; $display("FAIL mrst_stat got %h exp 20000000", d); end
    do_read(10'd7, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL mrst_scratch got %h exp 0", d); end
    do_read(10'd6, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL mrst_mask got %h exp 0", d); end
  endtask

  initial begin
    nRST = 1'b0; WE = 1'b0; WADDR = '0; WDATA = '0; RE = 1'b0; RADDR = '0;
    STATUS_IN = '0; CMD_READY = 1'b0; IRQ_SRC = '0;
    test_reset();
    test_rw_collision();
    test_fifo_fill();
    test_full_pop();
    test_irq();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/testdrive_slave_regfile.md
Name: testdrive_slave_regfile

Overview:
- Synthesizable slave-side responder for the TestDrive simple register bus (WE/WADDR/WDATA write channel, RE/RADDR/RDATA read channel), as driven by the virtual slave BFM.
- Provides ID, control, status, scratch and interrupt registers, plus a command FIFO that user logic drains through a valid/ready port.
- Sits between the bus master and user datapath logic in system-sim top levels.

Parameters:
- C_ADDR_BITS, 10, word-address width of WADDR/RADDR.
- C_ID, 32'h54440001, value returned by the ID register.
- C_CTRL_RESET, 32'h0, reset value of CTRL.
- C_FIFO_DEPTH, 16, command FIFO entries; power of 2, range 2..256.
- C_IRQ_BITS, 8, number of interrupt sources, range 1..29.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- nRST  in  1  reset, synchronous, active-low.
- WE  in  1  write strobe.
- WADDR  in  C_ADDR_BITS  write word address.
- WDATA  in  32  write data.
- RE  in  1  read strobe.
- RADDR  in  C_ADDR_BITS  read word address.
- RDATA  out  32  registered read data.
- CTRL  out  32  CTRL register contents.
- STATUS_IN  in  32  user status, returned by STATUS.
- CMD_VALID  out  1  FIFO non-empty.
- CMD_DATA  out  32  FIFO head entry.
- CMD_READY  in  1  user accepts the head entry.
- IRQ_SRC  in  C_IRQ_BITS  level interrupt sources.
- IRQ  out  1  registered interrupt request.

Behaviour:
- Reset: the register map below lists each register's reset value.
  - nRST low at a rising edge sets RDATA=0, CTRL=C_CTRL_RESET, FIFO empty (CMD_VALID=0), OVF=0, PEND=0, MASK=0, SCRATCH=0, IRQ=0.
  - An in-flight read returns nothing. Bus strobes are ignored while nRST is low.
- Decode: full C_ADDR_BITS compare.
  - Addresses 8 and above are unmapped: writes are ignored, reads return 0.
  - Writes to read-only registers are ignored.
- Register map (word addresses):
  - 0 ID, RO, =C_ID.
  - 1 CTRL, RW.
  - 2 STATUS, RO, =STATUS_IN, sampled at the read edge.
  - 3 CMD_PUSH, WO; reads return 0.
  - 4 FIFO_STAT, RO: bit31=OVF, bit30=full, bit29=empty, [8:0]=level, other bits 0.
  - 5 PEND, R/W1C.
  - 6 MASK, RW; bits above C_IRQ_BITS-1 read 0.
  - 7 SCRATCH, RW.
- Write: when WE=1 at edge N, the target register holds its new value after edge N. Latency is 1 cycle; no backpressure.
- Read: when RE=1 at edge N, RDATA holds the value as it was before edge N's updates, valid after edge N.
  - RDATA holds until the next RE.
  - RE=0 leaves RDATA unchanged.
- Simultaneous WE and RE: both execute in the same cycle. A read of the register being written returns the old value.
- FIFO pointers: C_FIFO_DEPTH entries, wrapping read/write pointers, level width $clog2(C_FIFO_DEPTH)+1.
- FIFO output: CMD_VALID = level!=0; CMD_DATA = head entry. Both are driven from registers with no combinational path from the bus.
- FIFO pop: occurs when CMD_VALID & CMD_READY at an edge.
- FIFO push (write to address 3):
  - Accepted if not full, or if a pop happens in the same cycle; when full with a simultaneous pop, level is unchanged.
  - Otherwise the data is dropped and OVF is set.
- OVF: sticky.
  - Cleared by a FIFO_STAT read; the read returns OVF=1.
  - If a new overflow happens in the same cycle as the clearing read, OVF stays 1.
- PEND[i]: set every edge where IRQ_SRC[i]=1.
  - Writing 1 to a bit clears it.
  - If set and clear occur in the same cycle, set wins.
- IRQ: registered |(PEND & MASK), so it follows PEND/MASK changes by 1 cycle.

Test Plan:
- Reset and ID: C_CTRL_RESET=32'hA5, reset, then read 0/1/6/7 -> RDATA = 32'h54440001, 32'hA5, 0, 0 respectively, each valid 1 cycle after RE. Read address 9 -> RDATA=0.
- RW and collision: write SCRATCH=32'hDEADBEEF together with RE to address 7 in the same cycle -> first RDATA=0. A second read returns 32'hDEADBEEF.
- FIFO fill/drain: CMD_READY=0, push 1..17 with depth 16 -> FIFO_STAT=32'hC0000010 (OVF, full, level 16). Re-read -> 32'h40000010. Raise CMD_READY -> CMD_DATA presents 1..16 in order, then CMD_VALID=0 and FIFO_STAT=32'h20000000.
- Full with simultaneous pop: FIFO full, push 32'h99 while CMD_READY=1 -> accepted, level stays 16, OVF=0, 32'h99 is the last entry out.
- Interrupt: MASK=32'h4, pulse IRQ_SRC[2] for 1 cycle -> PEND=32'h4, IRQ=1 one cycle later. Write PEND=32'h4 while IRQ_SRC[2]=1 -> PEND stays 4. With the source low, write PEND=32'h4 -> IRQ=0 two edges after the write.
- Mid-operation reset: FIFO holding 5 entries, OVF=1, IRQ=1, then nRST low for 1 cycle -> CMD_VALID=0, IRQ=0, FIFO_STAT=32'h20000000, CTRL=C_CTRL_RESET. A write with WE=1 during reset has no effect.
